amba_ahb_master: RTL and testbench

- AHB-Lite initiator that converts a simple command/response interface into AHB-Lite transfers toward the existing slave.
- Supports SINGLE and INCR4 transfers, read and write, byte/half/word sizes.
- Handles slave wait states (hready low) and the two-cycle ERROR response.
- Sits between the test/traffic logic and the slave's hsel/haddr/htrans/... ports; the same clock and reset drive both ends.

---
 rtl/amba_ahb_master.sv | 191 +++++++++++++++++++
 tb/tb_amba_ahb_master.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amba_ahb_master.sv
// -----------------------------------------------------------------------------
// amba_ahb_master
//
// AHB-Lite initiator. Turns a one-shot command (SINGLE or INCR4, read or
// write, byte/half/word) into pipelined AHB-Lite transfers and reports one
// response pulse per completed beat. Slave wait states stretch the current
// phase, and the two-cycle ERROR response ends the command early.
//
// Ports
//   hclk, hresetn        bus clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_write            1 = write, 0 = read
//   cmd_addr             start address
//   cmd_size             hsize encoding (0..2 legal)
//   cmd_incr4            1 = INCR4 burst, 0 = SINGLE
//   cmd_wdata            four write beats, beat k at [k*32 +: 32]
//   rsp_valid            one-cycle pulse per completed beat
//   rsp_rdata            read data of that beat (0 for writes and errors)
//   rsp_err              beat ended with ERROR or command was rejected
//   rsp_last             final response of the command
//   hsel..hwdata         AHB-Lite master outputs toward the slave
//   hrdata, hready, hresp  AHB-Lite slave returns
// -----------------------------------------------------------------------------
module amba_ahb_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [2:0]          cmd_size,
    input  logic                cmd_incr4,
    input  logic [4*DATA_W-1:0] cmd_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_last,
    output logic                hsel,
    output logic [ADDR_W-1:0]   haddr,
    output logic [1:0]          htrans,
    output logic                hwrite,
    output logic [2:0]          hsize,
    output logic [2:0]          hburst,
    output logic [3:0]          hprot,
    output logic [DATA_W-1:0]   hwdata,
    input  logic [DATA_W-1:0]   hrdata,
    input  logic                hready,
    input  logic                hresp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR,
        S_RSP
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    state_t              state;
    logic [4*DATA_W-1:0] wbuf;
    logic [1:0]          abeat;
    logic [1:0]          last_beat;
    logic                cmd_bad;

    assign cmd_ready = (state == S_IDLE);
    assign hprot     = 4'b0011;

    // Illegal size or an address not aligned to the transfer size.
    always_comb begin
        cmd_bad = 1'b0;
        if (cmd_size > 3'd2)
            cmd_bad = 1'b1;
        else if ((cmd_size == 3'd1) && cmd_addr[0])
            cmd_bad = 1'b1;
        else if ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00))
            cmd_bad = 1'b1;
    end

    // In S_ADDR, abeat is the beat whose address is on the bus; when it is
    // non-zero the data phase of beat abeat-1 overlaps it. S_DATA holds only
    // the final data phase, with the bus already idle.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            wbuf      <= '0;
            abeat     <= '0;
            last_beat <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_last  <= 1'b0;
            hsel      <= 1'b0;
            haddr     <= '0;
            htrans    <= TR_IDLE;
            hwrite    <= 1'b0;
            hsize     <= '0;
            hburst    <= '0;
            hwdata    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_last  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_bad) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_last  <= 1'b1;
                            state     <= S_RSP;
                        end else begin
                            hsel      <= 1'b1;
                            haddr     <= cmd_addr;
                            htrans    <= TR_NONSEQ;
                            hwrite    <= cmd_write;
                            hsize     <= cmd_size;
                            hburst    <= cmd_incr4 ? 3'b011 : 3'b000;
                            wbuf      <= cmd_wdata;
                            abeat     <= 2'd0;
                            last_beat <= cmd_incr4 ? 2'd3 : 2'd0;
                            state     <= S_ADDR;
                        end
                    end
                end
                S_RSP: begin
                    state <= S_IDLE;
                end
                S_ADDR: begin
                    if ((abeat != 2'd0) && hresp) begin
                        // ERROR on the overlapped data phase: drop the
                        // pending address and finish on the second cycle.
                        htrans <= TR_IDLE;
                        hsel   <= 1'b0;
                        if (hready) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_last  <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_ERR;
                        end
                    end else if (hready) begin
                        if (abeat != 2'd0) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= hwrite ? '0 : hrdata;
                        end
                        hwdata <= wbuf[int'(abeat)*DATA_W +: DATA_W];
                        if (abeat == last_beat) begin
                            htrans <= TR_IDLE;
                            hsel   <= 1'b0;
                            state  <= S_DATA;
                        end else begin
                            haddr  <= haddr + (ADDR_W'(1) << hsize);
                            htrans <= TR_SEQ;
                            abeat  <= abeat + 2'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (hready) begin
                        rsp_valid <= 1'b1;
                        rsp_last  <= 1'b1;
                        rsp_err   <= hresp;
                        rsp_rdata <= (hwrite || hresp) ? '0 : hrdata;
                        state     <= S_IDLE;
                    end else if (hresp) begin
                        state <= S_ERR;
                    end
                end
                S_ERR: begin
                    if (hready) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_last  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amba_ahb_master.sv
// -----------------------------------------------------------------------------
// tb_amba_ahb_master
//
// Drives commands into amba_ahb_master and plays the AHB-Lite slave itself.
// Expected responses, addresses and latencies come from a transaction-level
// model: per command, beat k lives at start + k*(1<<size), reads return
// rbase + k, and an ERROR on beat e truncates the response list after e.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_amba_ahb_master;

    logic         hclk;
    logic         hresetn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    logic [31:0]  cmd_addr;
    logic [2:0]   cmd_size;
    logic         cmd_incr4;
    logic [127:0] cmd_wdata;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         rsp_last;
    logic         hsel;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [2:0]   hsize;
    logic [2:0]   hburst;
    logic [3:0]   hprot;
    logic [31:0]  hwdata;
    logic [31:0]  hrdata;
    logic         hready;
    logic         hresp;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [31:0] exp_rdata[$];
    bit          exp_err[$];
    bit          exp_last[$];

    amba_ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_incr4(cmd_incr4),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_last(rsp_last),
        .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nextSample();
        @(posedge hclk);
        #1;
    endtask

    // Wait (bounded) for cmd_ready, then present one command for one edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic incr4,
                                 input logic [127:0] wd);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            nextSample();
            n++;
        end
        checkOutput("cmd_ready_wait", cmd_ready, 1);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_size  = size;
        cmd_incr4 = incr4;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
    endtask

    // Runs one command to completion, acting as the slave. w* are wait
    // cycles inserted at the start of each beat's data phase; eb is the
    // beat that gets the two-cycle ERROR response (-1 for none).
    task automatic runCmd(input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic incr4,
                          input logic [127:0] wd, input logic [31:0] rbase,
                          input int w0, input int w1, input int w2,
                          input int w3, input int eb);
        int          waits[4];
        int          nb, exp_naddr, n_addr, d_beat, wait_left, err_ph;
        int          cyc, done_cyc, total_wait;
        bit          bad, done, data_pending, drv_ready, drv_resp;
        logic [31:0] prev_haddr, prev_hwdata;
        logic [1:0]  prev_htrans;
        logic        prev_hsel, prev_hwrite;
        logic [2:0]  prev_hsize, prev_hburst;
        logic [31:0] e_rd;
        bit          e_err, e_last;

        waits[0] = w0; waits[1] = w1; waits[2] = w2; waits[3] = w3;
        nb  = incr4 ? 4 : 1;
        bad = (size > 3'd2) || ((size == 3'd1) && addr[0]) ||
              ((size == 3'd2) && (addr[1:0] != 2'b00));

        exp_rdata.delete(); exp_err.delete(); exp_last.delete();
        if (bad) begin
            exp_naddr = 0;
            exp_rdata.push_back(32'h0); exp_err.push_back(1); exp_last.push_back(1);
        end else begin
            exp_naddr = nb;
            for (int k = 0; k < nb; k++) begin
                if (k == eb) begin
                    exp_naddr = k + 1;
                    exp_rdata.push_back(32'h0); exp_err.push_back(1); exp_last.push_back(1);
                    break;
                end
                exp_rdata.push_back(wr ? 32'h0 : rbase + 32'(k));
                exp_err.push_back(0);
                exp_last.push_back(k == nb - 1);
            end
        end

        applyStimulus(wr, addr, size, incr4, wd);
        prev_haddr = haddr; prev_hwdata = hwdata; prev_htrans = htrans;
        prev_hsel = hsel; prev_hwrite = hwrite; prev_hsize = hsize;
        prev_hburst = hburst;
        drv_ready = hready; drv_resp = hresp;
        n_addr = 0; d_beat = 0; wait_left = 0; err_ph = 0;
        cyc = 0; done_cyc = 0; total_wait = 0;
        done = 0; data_pending = 0;

        while (!done && cyc < 80) begin
            nextSample();
            cmd_valid = 1'b0;

            // What the slave saw on the edge just passed.
            if (data_pending && drv_ready) begin
                if (wr && !drv_resp)
                    checkOutput("wdata_at_completion", prev_hwdata, wd[d_beat*32 +: 32]);
                data_pending = 0;
            end
            if (prev_hsel && prev_htrans[1] && drv_ready) begin
                checkOutput("beat_addr", prev_haddr, addr + (32'(n_addr) << size));
                checkOutput("beat_htrans", prev_htrans, (n_addr == 0) ? 2'b10 : 2'b11);
                checkOutput("beat_ctrl", {prev_hwrite, prev_hsize, prev_hburst},
                            {wr, size, incr4 ? 3'b011 : 3'b000});
                data_pending = 1;
                d_beat       = n_addr;
                n_addr++;
                wait_left    = waits[d_beat];
                err_ph       = 0;
            end

            if (cyc == 0 && !bad) begin
                checkOutput("first_nonseq", {hsel, htrans}, 3'b110);
                checkOutput("first_haddr", haddr, addr);
            end
            if (cyc == 0 && bad)
                checkOutput("reject_no_bus", {hsel, htrans}, 3'b000);
            if (!drv_ready && !drv_resp) begin
                checkOutput("wait_hold_haddr", haddr, prev_haddr);
                checkOutput("wait_hold_htrans", htrans, prev_htrans);
                checkOutput("wait_hold_hwdata", hwdata, prev_hwdata);
            end
            if (!drv_ready && drv_resp)
                checkOutput("err_cancel_htrans", htrans, 2'b00);
            if (data_pending && wr)
                checkOutput("hwdata_beat", hwdata, wd[d_beat*32 +: 32]);

            if (rsp_valid) begin
                if (exp_err.size() == 0) begin
                    checkOutput("rsp_extra", 1, 0);
                end else begin
                    e_rd = exp_rdata.pop_front();
                    e_err = exp_err.pop_front();
                    e_last = exp_last.pop_front();
                    checkOutput("rsp_err", rsp_err, e_err);
                    checkOutput("rsp_last", rsp_last, e_last);
                    if (!e_err)
                        checkOutput("rsp_rdata", rsp_rdata, e_rd);
                end
                if (rsp_last) begin
                    done     = 1;
                    done_cyc = cyc;
                end
            end

            // Slave drive for the next edge.
            if (data_pending && !done) begin
                hrdata = rbase + 32'(d_beat);
                if (d_beat == eb) begin
                    hready = (err_ph != 0);
                    hresp  = 1'b1;
                    err_ph = 1;
                end else if (wait_left > 0) begin
                    hready = 1'b0; hresp = 1'b0;
                    wait_left--;
                    total_wait++;
                end else begin
                    hready = 1'b1; hresp = 1'b0;
                end
            end else begin
                hready = 1'b1; hresp = 1'b0;
                hrdata = $urandom;
            end
            drv_ready = hready; drv_resp = hresp;
            prev_haddr = haddr; prev_hwdata = hwdata; prev_htrans = htrans;
            prev_hsel = hsel; prev_hwrite = hwrite; prev_hsize = hsize;
            prev_hburst = hburst;
            cyc++;
        end

        checkOutput("rsp_last_seen", done, 1);
        checkOutput("addr_count", n_addr, exp_naddr);
        checkOutput("rsp_left", exp_err.size(), 0);
        if (!bad && eb < 0)
            checkOutput("latency", done_cyc, nb + 1 + total_wait);
        if (bad) begin
            checkOutput("reject_ready_t1", cmd_ready, 0);
            nextSample();
            checkOutput("reject_ready_t2", cmd_ready, 1);
        end else begin
            checkOutput("ready_after_last", cmd_ready, 1);
            nextSample();
        end
        checkOutput("rsp_pulse_end", rsp_valid, 0);
    endtask

    initial begin
        logic         r_wr, r_incr4;
        logic [31:0]  r_addr;
        logic [2:0]   r_size;
        logic [127:0] r_wd;
        int           r_eb;

        hresetn   = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
        cmd_incr4 = 1'b0; cmd_wdata = '0;
        hrdata    = '0; hready = 1'b1; hresp = 1'b0;
        #1;
        checkOutput("reset_bus", {hsel, htrans, haddr, hwrite, hsize, hburst, hwdata},
                    '0);
        checkOutput("reset_rsp", {rsp_valid, rsp_err, rsp_last, rsp_rdata}, '0);
        checkOutput("reset_ready_prot", {cmd_ready, hprot}, 5'b1_0011);
        nextSample();
        nextSample();
        hresetn = 1'b1;
        nextSample();

        $display("[TB] directed commands");
        runCmd(1, 32'h10, 3'd2, 0, 128'hDEADBEEF, 32'h0, 0, 0, 0, 0, -1);
        runCmd(0, 32'h20, 3'd2, 1, '0, 32'h1, 0, 0, 0, 0, -1);
        runCmd(1, 32'h30, 3'd2, 1,
               128'h44444444_33333333_22222222_11111111, 32'h0, 0, 2, 0, 0, -1);
        runCmd(0, 32'h40, 3'd2, 1, '0, 32'hA0, 0, 0, 0, 0, 1);
        runCmd(1, 32'h102, 3'd2, 0, 128'h5, 32'h0, 0, 0, 0, 0, -1);
        runCmd(0, 32'h51, 3'd0, 1, '0, 32'h70, 1, 0, 1, 0, -1);
        runCmd(1, 32'h62, 3'd1, 1, {$urandom, $urandom, $urandom, $urandom},
               32'h0, 0, 0, 0, 1, -1);
        runCmd(0, 32'h80, 3'd2, 1, '0, 32'hB0, 0, 0, 0, 0, 3);

        $display("[TB] reset during INCR4");
        applyStimulus(0, 32'h40, 3'd2, 1, '0);
        nextSample();
        cmd_valid = 1'b0;
        hready = 1'b1; hresp = 1'b0; hrdata = 32'h1234;
        nextSample();
        nextSample();
        checkOutput("pre_reset_beat2", {htrans, haddr}, {2'b11, 32'h48});
        #2 hresetn = 1'b0;
        #1;
        checkOutput("async_reset_bus", {hsel, htrans, haddr, hwdata}, '0);
        checkOutput("async_reset_rsp", {rsp_valid, rsp_err, rsp_last}, 3'b000);
        checkOutput("async_reset_ready_prot", {cmd_ready, hprot}, 5'b1_0011);
        nextSample();
        checkOutput("in_reset_no_rsp", rsp_valid, 0);
        hresetn = 1'b1;
        nextSample();
        checkOutput("post_reset_idle", {cmd_ready, rsp_valid, htrans}, 4'b1000);
        runCmd(0, 32'h0, 3'd2, 0, '0, 32'hCAFE0000, 0, 0, 0, 0, -1);

        $display("[TB] randomized commands");
        for (int i = 0; i < 25; i++) begin
            r_wr    = 1'($urandom);
            r_incr4 = 1'($urandom);
            r_size  = (($urandom % 8) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            r_addr  = 32'($urandom_range(0, 63)) << 4;
            if (($urandom % 4) == 0)
                r_addr = r_addr | 32'($urandom_range(1, 3));
            r_wd    = {$urandom, $urandom, $urandom, $urandom};
            r_eb    = (($urandom % 5) == 0) ? $urandom_range(0, r_incr4 ? 3 : 0) : -1;
            runCmd(r_wr, r_addr, r_size, r_incr4, r_wd, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom_range(0, 2), r_eb);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
